// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD combinational reads, two byte-enabled write ports
// with port-1 priority, optional write-to-read bypass and a hardware clear sweep.
//
// state | meaning
// IDLE  | normal operation, port writes accepted
// CLEAR | sweeping reg[cnt] to zero, one register per edge; port writes dropped
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int NB      = WIDTH / 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NREAD*AW-1:0]    ra,
    output logic [NREAD*WIDTH-1:0] rd,
    input  logic                   we0,
    input  logic                   we1,
    input  logic [AW-1:0]          wa0,
    input  logic [AW-1:0]          wa1,
    input  logic [WIDTH-1:0]       wd0,
    input  logic [WIDTH-1:0]       wd1,
    input  logic [NB-1:0]          wbe0,
    input  logic [NB-1:0]          wbe1,
    input  logic                   clr_req,
    output logic                   busy
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t           state;
    logic [AW-1:0]    cnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] nxt [DEPTH];
    logic             eff0;
    logic             eff1;

    assign eff0 = we0 && !busy && ({1'b0, wa0} < DEPTH_W) && !((ZERO_REG != 0) && (wa0 == '0));
    assign eff1 = we1 && !busy && ({1'b0, wa1} < DEPTH_W) && !((ZERO_REG != 0) && (wa1 == '0));

    // Per-register next value; port 1 is applied last so it wins shared bytes.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            nxt[k] = mem[k];
            for (int b = 0; b < NB; b++) begin
                if (eff0 && (wa0 == AW'(k)) && wbe0[b])
                    nxt[k][b*8 +: 8] = wd0[b*8 +: 8];
                if (eff1 && (wa1 == AW'(k)) && wbe1[b])
                    nxt[k][b*8 +: 8] = wd1[b*8 +: 8];
            end
        end
    end

    // Out-of-range addresses match no register and fall through to zero.
    always_comb begin
        rd = '0;
        for (int i = 0; i < NREAD; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if ((ra[i*AW +: AW] == AW'(k)) && !((ZERO_REG != 0) && (k == 0)))
                    rd[i*WIDTH +: WIDTH] = ((BYPASS != 0) && !busy) ? nxt[k] : mem[k];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            for (int k = 0; k < DEPTH; k++)
                mem[k] <= '0;
        end else begin
            if (state == IDLE) begin
                if (clr_req) begin
                    state <= CLEAR;
                    busy  <= 1'b1;
                    cnt   <= '0;
                end
            end else begin
                cnt <= cnt + 1'b1;
                if (cnt == LAST) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            end
            for (int k = 0; k < DEPTH; k++) begin
                if ((state == CLEAR) && (cnt == AW'(k)))
                    mem[k] <= '0;
                else
                    mem[k] <= nxt[k];
            end
        end
    end

endmodule
